branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  ID-stage branch resolver that consumes the forwarded branch operands (Branch_alu_data1/2).
//  Detects branch data hazards that forwarding cannot cover and stalls PC/IFID while bubbling IDEX.
//  Once operands are valid it evaluates the branch condition, drives the PC redirect target and flushes IFID.
// PARAMETERS
//  DATA_W   32  operand/PC width
//  PERF_W   32  width of each performance counter (BRANCH_PERF_EN only)
// PORTS
//  clk               in   1       clock, rising edge
//  rst               in   1       asynchronous reset, active-high
//  Branch_in         in   1       IFID instruction is a conditional branch
//  funct3            in   3       branch type from the IFID instruction
//  Branch_alu_data1  in   DATA_W  forwarded rs1 operand
//  Branch_alu_data2  in   DATA_W  forwarded rs2 operand
//  IFID_PC           in   DATA_W  PC of the branch
//  imm               in   DATA_W  sign-extended B-immediate
//  IFID_RegisterRs1  in   5       branch rs1
//  IFID_RegisterRs2  in   5       branch rs2
//  IDEX_RegWrite     in   1       IDEX instruction writes rd
//  IDEX_MemRead      in   1       IDEX instruction is a load
//  IDEX_RegisterRd   in   5       IDEX rd
//  EXMEM_MemRead     in   1       EXMEM instruction is a load
//  EXMEM_RegisterRd  in   5       EXMEM rd
//  PC_stall          out  1       hold the PC
//  IFID_stall        out  1       hold the IFID register
//  IDEX_bubble       out  1       insert a NOP into IDEX
//  branch_taken      out  1       redirect the PC this cycle
//  branch_target     out  DATA_W  IFID_PC+imm, modulo 2^DATA_W
//  IFID_flush        out  1       squash the fetched instruction
//  perf_branches/perf_taken/perf_stall_cycles  out  PERF_W  counters
// BEHAVIOUR
//  - match(rd) = rd!=0 && (rd==Rs1 || rd==Rs2). Register x0 never causes a hazard.
//  - need (evaluated only when Branch_in is high):
//      2 if IDEX_MemRead && match(IDEX_Rd)
//      else 1 if IDEX_RegWrite && match(IDEX_Rd)
//      else 1 if EXMEM_MemRead && match(EXMEM_Rd)
//      else 0
//    When the rs1 and rs2 hazards differ, the larger need applies.
//  - FSM states: IDLE and STALL, with a 2-bit cnt.
//    IDLE with need>0: assert the stall outputs this cycle and load cnt=need-1.
//      Go to STALL if cnt!=0; otherwise stay in IDLE and re-evaluate next cycle.
//    STALL: assert the stall outputs and decrement cnt. Return to IDLE in the cycle cnt reaches 0.
//      Hazards are ignored while in STALL.
//  - "Stall outputs" means PC_stall = IFID_stall = IDEX_bubble = 1 (all asserted together).
//  - Resolve: in IDLE with Branch_in && need==0, the outcome is combinational (0-cycle latency).
//    funct3 encodings: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
//    010/011 are never taken.
//    Taken: branch_taken=1, IFID_flush=1, branch_target=IFID_PC+imm (carry dropped).
//    branch_taken and IFID_flush are never asserted in the same cycle as a stall.
//  - branch_target always shows the sum; it is used only when branch_taken is high.
//  - Reset (including mid-STALL): state=IDLE, cnt=0. All 1-bit outputs are 0 and counters are 0.
//    Outputs are forced to 0 while rst is high.
// CONFIGURATION
//  BRANCH_PERF_EN defined:
//    perf_branches  +1 per resolved branch
//    perf_taken     +1 per taken branch
//    perf_stall_cycles  +1 per stall cycle
//    All counters saturate at all-ones and are cleared by rst.
//  BRANCH_PERF_EN undefined: no counter flops; the perf_* ports are tied to 0.
// TESTING
//  1. BEQ, data1=data2=5, no hazard
//     -> same cycle: branch_taken=1, IFID_flush=1, target=PC+imm (PC=0x100, imm=-8 -> 0xF8).
//  2. BLT with data1=0xFFFFFFFF, data2=1 -> taken.
//     BLTU with the same operands -> not taken, no flush.
//  3. Load to x5 in IDEX, branch reads x5 -> exactly 2 stall cycles with IDEX_bubble=1,
//     then resolution on the 3rd cycle.
//  4. ALU op writing x0 in IDEX, branch on x0 -> 0 stalls.
//     ALU op writing x7 with rs2=x7 -> 1 stall.
//  5. Assert rst during the 2nd stall cycle -> all outputs 0 immediately; IDLE after release.
//  6. With BRANCH_PERF_EN: 3 branches (2 taken, 3 stall cycles) -> counters read 3/2/3.
//     With PERF_W=2, counters saturate at 3.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// ID-stage branch resolver. Detects operand hazards that forwarding cannot
// cover (load in IDEX, ALU result in IDEX, load in EXMEM), stalls PC/IFID
// while bubbling IDEX, and otherwise resolves the branch combinationally:
// condition evaluation, PC redirect target and IFID flush.
// Optional feature macro: BRANCH_PERF_EN (saturating performance counters).
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int DATA_W = 32,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Branch_in,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] Branch_alu_data1,
    input  logic [DATA_W-1:0] Branch_alu_data2,
    input  logic [DATA_W-1:0] IFID_PC,
    input  logic [DATA_W-1:0] imm,
    input  logic [4:0]        IFID_RegisterRs1,
    input  logic [4:0]        IFID_RegisterRs2,
    input  logic              IDEX_RegWrite,
    input  logic              IDEX_MemRead,
    input  logic [4:0]        IDEX_RegisterRd,
    input  logic              EXMEM_MemRead,
    input  logic [4:0]        EXMEM_RegisterRd,
    output logic              PC_stall,
    output logic              IFID_stall,
    output logic              IDEX_bubble,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic              IFID_flush,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_taken,
    output logic [PERF_W-1:0] perf_stall_cycles
);

    typedef enum logic [0:0] {IDLE = 1'b0, STALL = 1'b1} state_t;

    state_t      state, state_next;
    logic [1:0]  cnt, cnt_next;
    logic [1:0]  need;
    logic        cond;
    logic        stall;
    logic        taken;

    // A destination register conflicts with the branch operands unless it is x0.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

    // Branch condition by funct3; reserved encodings are never taken.
    function automatic logic branch_cond(input logic [2:0] f3, input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
        logic r;
        case (f3)
            3'b000:  r = (a == b);
            3'b001:  r = (a != b);
            3'b100:  r = ($signed(a) <  $signed(b));
            3'b101:  r = ($signed(a) >= $signed(b));
            3'b110:  r = (a <  b);
            3'b111:  r = (a >= b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Stall depth required by the closest conflicting producer; load-use in IDEX needs two.
    always_comb begin
        need = 2'd0;
        if (Branch_in) begin
            if (IDEX_MemRead && reg_match(IDEX_RegisterRd, IFID_RegisterRs1, IFID_RegisterRs2)) begin
                need = 2'd2;
            end else if (IDEX_RegWrite && reg_match(IDEX_RegisterRd, IFID_RegisterRs1, IFID_RegisterRs2)) begin
                need = 2'd1;
            end else if (EXMEM_MemRead && reg_match(EXMEM_RegisterRd, IFID_RegisterRs1, IFID_RegisterRs2)) begin
                need = 2'd1;
            end else begin
                need = 2'd0;
            end
        end else begin
            need = 2'd0;
        end
    end

    assign cond = branch_cond(funct3, Branch_alu_data1, Branch_alu_data2);

    // Next-state and raw stall/taken decisions of the hazard FSM.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        taken      = 1'b0;
        case (state)
            IDLE: begin
                if (Branch_in && (need != 2'd0)) begin
                    stall    = 1'b1;
                    cnt_next = need - 2'd1;
                    if ((need - 2'd1) != 2'd0) begin
                        state_next = STALL;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (Branch_in) begin
                    taken = cond;
                end else begin
                    taken = 1'b0;
                end
            end
            STALL: begin
                stall = 1'b1;
                if (cnt <= 2'd1) begin
                    cnt_next   = 2'd0;
                    state_next = IDLE;
                end else begin
                    cnt_next   = cnt - 2'd1;
                    state_next = STALL;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 2'd0;
            end
        endcase
    end

    // FSM state and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Outputs are combinational for zero-latency resolve, and held low during reset.
    assign PC_stall      = stall & ~rst;
    assign IFID_stall    = stall & ~rst;
    assign IDEX_bubble   = stall & ~rst;
    assign branch_taken  = taken & ~rst;
    assign IFID_flush    = taken & ~rst;
    assign branch_target = rst ? {DATA_W{1'b0}} : (IFID_PC + imm);

`ifdef BRANCH_PERF_EN
    logic [PERF_W-1:0] cnt_branches, cnt_taken, cnt_stalls;
    logic              resolved;

    assign resolved = (state == IDLE) && Branch_in && (need == 2'd0);

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : (v + PERF_W'(1));
    endfunction

    // Saturating event counters for resolved branches, taken branches and stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_branches <= {PERF_W{1'b0}};
            cnt_taken    <= {PERF_W{1'b0}};
            cnt_stalls   <= {PERF_W{1'b0}};
        end else begin
            if (resolved) cnt_branches <= sat_inc(cnt_branches);
            if (taken)    cnt_taken    <= sat_inc(cnt_taken);
            if (stall)    cnt_stalls   <= sat_inc(cnt_stalls);
        end
    end

    assign perf_branches     = cnt_branches;
    assign perf_taken        = cnt_taken;
    assign perf_stall_cycles = cnt_stalls;
`else
    assign perf_branches     = {PERF_W{1'b0}};
    assign perf_taken        = {PERF_W{1'b0}};
    assign perf_stall_cycles = {PERF_W{1'b0}};
`endif

endmodule
